// File: rtl/neuron_bs_n_pkg.sv
// Shared state codes, accumulator sizing and weight-field helpers for the bit-serial neuron.
// A weight entry is {sign, shift}; sign=1 negates the input before the arithmetic right shift.
package neuron_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RECV = 3'd1;
    localparam logic [2:0] ST_COMP = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_SEND = 3'd4;

    // Two extra bits: one for the sign, one of headroom for the negated full-scale input.
    function automatic int acc_w(input int dw, input int n);
        return dw + $clog2(n) + 2;
    endfunction

    function automatic logic wsign(input logic [31:0] entry, input int shw);
        logic [31:0] t;
        t = entry >> shw;
        return t[0];
    endfunction

    function automatic logic [31:0] wshift(input logic [31:0] entry, input int shw);
        return entry & ((32'd1 << shw) - 32'd1);
    endfunction

endpackage

// File: rtl/neuron_bs_n_if.sv
// Bit-serial REQ/ACK/DATA links around one neuron: N input channels and one output channel.
// slave = the neuron side, master = the fabric side that feeds and drains it.
interface neuron_bs_n_if #(
    parameter int N = 4
);
    logic [N-1:0] IN_REQ;
    logic [N-1:0] IN_ACK;
    logic [N-1:0] IN_DATA;
    logic         OUT_REQ;
    logic         OUT_ACK;
    logic         OUT_DATA;

    modport master (
        input  IN_REQ, OUT_ACK, OUT_DATA,
        output IN_ACK, IN_DATA, OUT_REQ
    );

    modport slave (
        output IN_REQ, OUT_ACK, OUT_DATA,
        input  IN_ACK, IN_DATA, OUT_REQ
    );
endinterface

// File: rtl/neuron_bs_n_serial_rx_lane.sv
// One serial input channel: accepts a DW-bit LSB-first word after an ACK while requesting and not done.
// Word is complete (o_done) on the edge capturing bit DW-1; o_req stays low until i_rearm.
module serial_rx_lane #(
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RSTB,
    input  logic          i_ack,
    input  logic          i_data,
    input  logic          i_clr,
    input  logic          i_rearm,
    output logic          o_req,
    output logic          o_acc,
    output logic          o_done,
    output logic [DW-1:0] o_word
);
    localparam int CW = $clog2(DW);

    logic          r_req;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_sh;
    logic          w_acc;

    // ACKs while busy, done or not requesting are protocol errors and are dropped.
    assign w_acc = i_ack && r_req && !r_done;

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            r_req  <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_sh   <= '0;
        end else begin
            if (w_acc) begin
                r_req  <= 1'b0;
                r_busy <= 1'b1;
                r_cnt  <= CW'(1);
                r_sh   <= {i_data, r_sh[DW-1:1]};
            end else if (r_busy) begin
                r_sh  <= {i_data, r_sh[DW-1:1]};
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(DW-1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
            if (i_clr) begin
                r_done <= 1'b0;
            end
            if (i_rearm) begin
                r_req <= 1'b1;
            end
        end
    end

    assign o_req  = r_req;
    assign o_acc  = w_acc;
    assign o_done = r_done;
    assign o_word = r_sh;
endmodule

// File: rtl/neuron_bs_n.sv
// N-input bit-serial neuron: sum of sign/shift-weighted inputs, ReLU, serial result (NEURON_SAT_EN: saturate, else wrap).
// Latency: last input bit at edge t -> OUT_ACK at t+3; result held in HOLD while OUT_REQ=0.
module neuron_bs_n
    import neuron_pkg::*;
#(
    parameter int                   N     = 4,
    parameter int                   DW    = 8,
    parameter int                   SHW   = 3,
    parameter logic [N*(SHW+1)-1:0] W_VEC = '0
) (
    input  logic           CLK,
    input  logic           RSTB,
    neuron_bs_n_if.slave   bus
);
    localparam int AW = acc_w(DW, N);
    localparam int KW = $clog2(DW);

    logic [N-1:0]           w_req;
    logic [N-1:0]           w_acc;
    logic [N-1:0]           w_done;
    logic [DW-1:0]          w_word [N];
    logic                   w_clr;
    logic                   w_rearm;
    logic signed [AW-1:0]   w_sum;
    logic [DW-1:0]          w_relu;

    logic [2:0]             r_st;
    logic [DW-1:0]          r_res;
    logic [KW-1:0]          r_k;
    logic                   r_ack;
    logic                   r_dat;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        serial_rx_lane #(.DW(DW)) u_lane (
            .CLK     (CLK),
            .RSTB    (RSTB),
            .i_ack   (bus.IN_ACK[gi]),
            .i_data  (bus.IN_DATA[gi]),
            .i_clr   (w_clr),
            .i_rearm (w_rearm),
            .o_req   (w_req[gi]),
            .o_acc   (w_acc[gi]),
            .o_done  (w_done[gi]),
            .o_word  (w_word[gi])
        );
    end

    assign w_clr   = (r_st == ST_COMP);
    assign w_rearm = (r_st == ST_SEND) && (r_k == KW'(DW-1));

    always_comb begin
        logic signed [AW-1:0] v;
        logic [31:0]          e;
        v     = '0;
        e     = '0;
        w_sum = '0;
        for (int i = 0; i < N; i++) begin
            e = 32'(W_VEC[i*(SHW+1) +: SHW+1]);
            v = signed'(AW'(w_word[i]));
            // >>> on the negated value floors toward minus infinity.
            if (wsign(e, SHW)) begin
                v = (-v) >>> wshift(e, SHW);
            end else begin
                v = v >>> wshift(e, SHW);
            end
            w_sum = w_sum + v;
        end
    end

`ifdef NEURON_SAT_EN
    localparam logic signed [AW-1:0] MAXV = signed'(AW'({DW{1'b1}}));
`endif

    always_comb begin
        w_relu = '0;
        if (!w_sum[AW-1] && (w_sum != '0)) begin
`ifdef NEURON_SAT_EN
            if (w_sum > MAXV) begin
                w_relu = '1;
            end else begin
                w_relu = w_sum[DW-1:0];
            end
`else
            w_relu = w_sum[DW-1:0];
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            r_st  <= ST_IDLE;
            r_res <= '0;
            r_k   <= '0;
            r_ack <= 1'b0;
            r_dat <= 1'b0;
        end else begin
            case (r_st)
                ST_IDLE: if (|w_acc) r_st <= ST_RECV;
                ST_RECV: if (&w_done) r_st <= ST_COMP;
                ST_COMP: begin
                    r_res <= w_relu;
                    r_st  <= ST_HOLD;
                end
                ST_HOLD: if (bus.OUT_REQ) begin
                    r_ack <= 1'b1;
                    r_dat <= r_res[0];
                    r_k   <= KW'(1);
                    r_st  <= ST_SEND;
                end
                ST_SEND: begin
                    r_ack <= 1'b0;
                    r_dat <= r_res[r_k];
                    if (r_k == KW'(DW-1)) begin
                        r_st <= ST_IDLE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                default: r_st <= ST_IDLE;
            endcase
        end
    end

    assign bus.IN_REQ   = w_req;
    assign bus.OUT_ACK  = r_ack;
    assign bus.OUT_DATA = r_dat;
endmodule

// File: tb/tb_neuron_bs_n.sv
// Two neurons (mixed weights, all-zero weights) share stimulus; results compared to an arithmetic model.
module tb_neuron_bs_n;
    localparam logic [15:0] WA = {4'b0010, 4'b1000, 4'b0001, 4'b0000};

    logic       CLK = 1'b0;
    logic       RSTB;
    logic [3:0] ack;
    logic [3:0] dat;
    logic       oreq;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] xv [4];
    int         st [4];
    logic [7:0] ra, rb;
    int         lat;

    always #5 CLK = ~CLK;

    neuron_bs_n_if #(.N(4)) ifa ();
    neuron_bs_n_if #(.N(4)) ifb ();

    assign ifa.IN_ACK  = ack;
    assign ifa.IN_DATA = dat;
    assign ifa.OUT_REQ = oreq;
    assign ifb.IN_ACK  = ack;
    assign ifb.IN_DATA = dat;
    assign ifb.OUT_REQ = oreq;

    neuron_bs_n #(.N(4), .DW(8), .SHW(3), .W_VEC(WA)) u_dut_a (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (ifa.slave)
    );

    neuron_bs_n #(.N(4), .DW(8), .SHW(3), .W_VEC(16'h0000)) u_dut_b (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (ifb.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Weighted sum with floor division for negatives, then ReLU and 8-bit saturate/wrap.
    function automatic int model(input logic [7:0] x [4], input logic [15:0] wv);
        int s, v, d;
        logic [3:0] e;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            e = wv[i*4 +: 4];
            v = int'(x[i]);
            d = 1 << e[2:0];
            if (e[3]) v = -v;
            if (v >= 0) s += v / d;
            else        s -= (-v + d - 1) / d;
        end
        if (s <= 0) return 0;
`ifdef NEURON_SAT_EN
        if (s > 255) return 255;
`endif
        return s % 256;
    endfunction

    task automatic drive(input logic [7:0] x [4], input int sv [4], input int xch, input int xcyc);
        int last;
        last = 0;
        for (int i = 0; i < 4; i++) if (sv[i] + 7 > last) last = sv[i] + 7;
        for (int c = 0; c <= last; c++) begin
            for (int i = 0; i < 4; i++) begin
                ack[i] = (c == sv[i]) || (i == xch && c == xcyc);
                if (c >= sv[i] && c <= sv[i] + 7) dat[i] = x[i][c - sv[i]];
                else                              dat[i] = 1'($urandom_range(0, 1));
            end
            tick();
            for (int i = 0; i < 4; i++) check("in_req", ifa.IN_REQ[i], (c < sv[i]) ? 1 : 0);
        end
        ack = '0;
    endtask

    task automatic recv(output logic [7:0] a, output logic [7:0] b, output int l, input int budget);
        l = -1;
        a = '0;
        b = '0;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (ifa.OUT_ACK) begin
                l = c;
                break;
            end
        end
        check("out_ack_seen", ifa.OUT_ACK, 1);
        if (l < 0) return;
        check("out_ack_b", ifb.OUT_ACK, 1);
        a[0] = ifa.OUT_DATA;
        b[0] = ifb.OUT_DATA;
        for (int k = 1; k < 8; k++) begin
            tick();
            if (k == 1) check("ack_pulse", ifa.OUT_ACK, 0);
            a[k] = ifa.OUT_DATA;
            b[k] = ifb.OUT_DATA;
        end
    endtask

    task automatic run_txn(input int hold, input int xch, input int xcyc);
        logic seen, rq;
        oreq = (hold == 0);
        drive(xv, st, xch, xcyc);
        if (hold > 0) begin
            seen = 1'b0;
            rq   = 1'b0;
            for (int h = 0; h < hold + 2; h++) begin
                tick();
                seen |= ifa.OUT_ACK;
                rq   |= (ifa.IN_REQ != 4'h0);
            end
            check("hold_no_ack", seen, 0);
            check("hold_in_req", rq, 0);
            oreq = 1'b1;
        end
        recv(ra, rb, lat, 40);
        check("latency", lat, (hold > 0) ? 1 : 3);
        check("res_a", ra, model(xv, WA));
        check("res_b", rb, model(xv, 16'h0000));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        logic seen;
        RSTB = 1'b0;
        ack  = '0;
        dat  = '0;
        oreq = 1'b1;
        tick();
        tick();
        check("rst_in_req", ifa.IN_REQ, 4'hF);
        check("rst_out_ack", ifa.OUT_ACK, 0);
        check("rst_out_data", ifa.OUT_DATA, 0);
        check("rst_in_req_b", ifb.IN_REQ, 4'hF);
        RSTB = 1'b1;
        tick();

        // simultaneous arrivals, sum 92
        xv = '{8'd100, 8'd40, 8'd30, 8'd8};
        st = '{0, 0, 0, 0};
        run_txn(0, -1, -1);

        // negative sum clamps to zero
        xv = '{8'd10, 8'd0, 8'd200, 8'd0};
        run_txn(0, -1, -1);

        // full scale: wrap or saturate on the zero-weight neuron
        xv = '{8'd255, 8'd255, 8'd255, 8'd255};
        run_txn(0, -1, -1);

        // staggered, extra ACK on an already-done channel
        xv = '{8'd100, 8'd40, 8'd30, 8'd8};
        st = '{13, 4, 9, 0};
        run_txn(0, 3, 10);

        // output backpressure for 20 cycles
        st = '{0, 0, 0, 0};
        run_txn(20, -1, -1);

        // reset during SEND bit 4
        xv = '{8'd77, 8'd200, 8'd3, 8'd160};
        oreq = 1'b1;
        drive(xv, st, -1, -1);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ifa.OUT_ACK) break;
        end
        check("t6_ack", ifa.OUT_ACK, 1);
        repeat (4) tick();
        RSTB = 1'b0;
        tick();
        RSTB = 1'b1;
        check("t6_out_ack", ifa.OUT_ACK, 0);
        check("t6_out_data", ifa.OUT_DATA, 0);
        check("t6_in_req", ifa.IN_REQ, 4'hF);
        check("t6_out_data_b", ifb.OUT_DATA, 0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            seen |= ifa.OUT_ACK;
        end
        check("t6_idle_no_ack", seen, 0);
        xv = '{8'd9, 8'd60, 8'd4, 8'd255};
        run_txn(0, -1, -1);

        // randomized traffic
        for (int r = 0; r < 30; r++) begin
            int xch, xcyc, hold;
            for (int i = 0; i < 4; i++) begin
                xv[i] = 8'($urandom_range(0, 255));
                st[i] = int'($urandom_range(0, 12));
            end
            last = 0;
            for (int i = 0; i < 4; i++) if (st[i] + 7 > last) last = st[i] + 7;
            xch  = int'($urandom_range(0, 3));
            xcyc = st[xch] + int'($urandom_range(1, last - st[xch]));
            hold = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
            run_txn(hold, xch, xcyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
